alu_issue_seq: RTL
==================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 SHALL have parameter DW, default 8, meaning datapath width of ALU result and writeback data.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port instr_valid  input  1  instruction offered by fetch.
REQ-005 SHALL have port instr  input  9  instruction word: [8:6] cmd, [5:4] type, [3:1] subop/count, [0] v.
REQ-006 SHALL have port instr_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have ports alu_cmd(3), Type(2), M_op(3), C_op(2), A_op(3), V_op(1), all output, meaning decoded ALU controls.
REQ-008 SHALL have port sc_i  output  1  shift-carry input to ALU, always equal to flag_sc.
REQ-009 SHALL have ports alu_rslt(DW), alu_sc_o(1), alu_pari(1), alu_zero(1), all input, meaning combinational ALU outputs.
REQ-010 SHALL have ports wb_en(1), wb_data(DW), output, meaning registered writeback strobe and data.
REQ-011 SHALL have ports flag_sc, flag_pari, flag_zero, output, 1 each, meaning registered status flags.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, WB; instr_ready = (state==IDLE).
REQ-014 SHALL accept an instruction only on instr_valid & instr_ready; accepted word latched into an internal instruction register.
REQ-015 SHALL, on accepting type==2'b11 with cmd not in {101,110}, treat it as NOP: stay IDLE, no wb_en, flags unchanged.
REQ-016 SHALL, on any other accept, go IDLE->EXEC next edge.
REQ-017 SHALL in EXEC drive alu_cmd=instr[8:6], V_op=instr[0], Type=instr[5:4].
REQ-018 SHALL in EXEC decode sub-ops: type 00 -> M_op=instr[3:1]; type 01 -> C_op=instr[2:1]; type 10 -> A_op=instr[3:1]; unselected sub-op fields 0.
REQ-019 SHALL in EXEC, for cmd 101 or 110 (shift/rotate), drive Type, M_op, C_op, A_op all 0; instr[3:1] is iteration count minus one (1..8 iterations).
REQ-020 SHALL drive alu_cmd, Type, M_op, C_op, A_op, V_op to 0 in IDLE and WB.
REQ-021 SHALL at the EXEC->WB edge register wb_data<=alu_rslt, flag_sc<=alu_sc_o, flag_pari<=alu_pari, flag_zero<=alu_zero.
REQ-022 SHALL assert wb_en for exactly the WB cycle of every iteration; wb_data holds until the next capture.
REQ-023 SHALL from WB go to EXEC if iterations remain, else IDLE; iteration k uses sc_i = flag_sc from iteration k-1.
REQ-024 SHALL give latency: accept at edge N, EXEC cycle N+1, wb_en high cycle N+2, instr_ready high cycle N+3 (single iteration).
REQ-025 SHALL ignore instr_valid and instr while busy; no queueing.
REQ-026 SHALL leave flags unchanged except at capture edges.

Reset
REQ-027 SHALL on reset (async assert, any state) force IDLE, clear instruction register, iteration counter, wb_data, all flags, wb_en, busy; abandon remaining iterations.
REQ-028 SHALL present instr_ready=1 on the first edge after reset deasserts.

Verification
REQ-029 SHALL verify single op: instr=9'b001_00_010_1, alu_rslt=8'h02, alu_zero=0 -> EXEC: alu_cmd=001, M_op=010, V_op=1; next cycle wb_en=1, wb_data=8'h02, flag_zero=0.
REQ-030 SHALL verify repeat: instr=9'b101_00_011_0, ALU stub returns alu_sc_o=1 each step -> four EXEC/WB pairs, four wb_en pulses, sc_i=0 in first EXEC, 1 in later EXECs, busy high 8 cycles.
REQ-031 SHALL verify NOP: instr=9'b010_11_000_0 -> instr_ready stays 1, no wb_en, flags unchanged, ALU controls stay 0.
REQ-032 SHALL verify back-pressure: instr_valid held high with new word during EXEC/WB -> word accepted only in next IDLE cycle, exactly once.
REQ-033 SHALL verify reset mid-repeat: assert reset during second EXEC of an 8-iteration shift -> all outputs 0 immediately, no further wb_en, instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue_seq.sv
// ---------------------------------------------------------------------------
// alu_issue_seq
//
// Single-issue sequencer sitting between instruction fetch and an external
// combinational ALU. An accepted instruction is held in an internal register,
// decoded into ALU controls for one EXEC cycle, and the ALU result and status
// are captured into writeback/flag registers at the EXEC->WB edge. Shift and
// rotate commands (cmd 101/110) repeat EXEC/WB up to eight times, feeding the
// previous shift-carry back through sc_i.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   instr_valid, instr   instruction offer from fetch ([8:6] cmd, [5:4] type,
//                        [3:1] subop / shift count-1, [0] v)
//   instr_ready          high while IDLE (an offer is taken this cycle)
//   alu_cmd, Type, M_op, C_op, A_op, V_op
//                        decoded ALU controls, non-zero only in EXEC
//   sc_i                 shift-carry into the ALU (mirror of flag_sc)
//   alu_rslt, alu_sc_o, alu_pari, alu_zero
//                        combinational ALU outputs
//   wb_en, wb_data       writeback strobe (WB cycle) and held result
//   flag_sc, flag_pari, flag_zero
//                        registered status flags
//   busy                 high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module alu_issue_seq #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    input  logic [8:0]    instr,
    output logic          instr_ready,
    output logic [2:0]    alu_cmd,
    output logic [1:0]    Type,
    output logic [2:0]    M_op,
    output logic [1:0]    C_op,
    output logic [2:0]    A_op,
    output logic          V_op,
    output logic          sc_i,
    input  logic [DW-1:0] alu_rslt,
    input  logic          alu_sc_o,
    input  logic          alu_pari,
    input  logic          alu_zero,
    output logic          wb_en,
    output logic [DW-1:0] wb_data,
    output logic          flag_sc,
    output logic          flag_pari,
    output logic          flag_zero,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [8:0]    instr_q, instr_d;
    logic [2:0]    iter_q, iter_d;      // iterations still to run after the current one
    logic          wb_en_q, wb_en_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          sc_q, sc_d;
    logic          pari_q, pari_d;
    logic          zero_q, zero_d;

    function automatic logic is_shift(input logic [2:0] cmd);
        return (cmd == 3'b101) || (cmd == 3'b110);
    endfunction

    // Type 11 is only meaningful for shift/rotate; anything else is a NOP.
    function automatic logic is_nop(input logic [8:0] w);
        return (w[5:4] == 2'b11) && !is_shift(w[8:6]);
    endfunction

    logic accept;
    assign accept = instr_valid && (state_q == S_IDLE);

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        iter_d    = iter_q;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        sc_d      = sc_q;
        pari_d    = pari_q;
        zero_d    = zero_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    instr_d = instr;
                    if (!is_nop(instr)) begin
                        state_d = S_EXEC;
                        iter_d  = is_shift(instr[8:6]) ? instr[3:1] : 3'd0;
                    end
                end
            end
            S_EXEC: begin
                // Capture the ALU outputs produced from this cycle's controls.
                state_d   = S_WB;
                wb_en_d   = 1'b1;
                wb_data_d = alu_rslt;
                sc_d      = alu_sc_o;
                pari_d    = alu_pari;
                zero_d    = alu_zero;
            end
            S_WB: begin
                if (iter_q != 3'd0) begin
                    iter_d  = iter_q - 3'd1;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            iter_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_data_q <= '0;
            sc_q      <= 1'b0;
            pari_q    <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            iter_q    <= iter_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
            sc_q      <= sc_d;
            pari_q    <= pari_d;
            zero_q    <= zero_d;
        end
    end

    // Controls are decoded from the held instruction and gated to EXEC only.
    always_comb begin
        alu_cmd = 3'd0;
        Type    = 2'd0;
        M_op    = 3'd0;
        C_op    = 2'd0;
        A_op    = 3'd0;
        V_op    = 1'b0;
        if (state_q == S_EXEC) begin
            alu_cmd = instr_q[8:6];
            V_op    = instr_q[0];
            // For shift/rotate instr[3:1] is a repeat count, not a sub-op.
            if (!is_shift(instr_q[8:6])) begin
                Type = instr_q[5:4];
                case (instr_q[5:4])
                    2'b00:   M_op = instr_q[3:1];
                    2'b01:   C_op = instr_q[2:1];
                    2'b10:   A_op = instr_q[3:1];
                    default: ;
                endcase
            end
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign sc_i        = sc_q;
    assign wb_en       = wb_en_q;
    assign wb_data     = wb_data_q;
    assign flag_sc     = sc_q;
    assign flag_pari   = pari_q;
    assign flag_zero   = zero_q;

endmodule
